complex_mul: RTL and testbench

- Pipelined signed complex multiplier: product = c1 × c2 on packed {real, imag} two's-complement operands.
- Sits in the datapath as a leaf arithmetic block.
- Fully pipelined: accepts one operand pair per cycle, no backpressure.
- Fixed latency of 2 cycles, with a valid strobe travelling alongside the data.

---
 rtl/complex_mul_pkg.sv | 38 +++
 rtl/complex_mul_pp.sv | 72 +++++++
 rtl/complex_mul.sv | 93 +++++++++
 tb/tb_complex_mul.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/complex_mul_pkg.sv
// rtl/complex_mul_pkg.sv - shared constants and result-fitting helper for complex_mul
//
// Purpose: default component width, packed field positions for the default
// width, and the function that reduces a widened sum/difference to 2W bits
// (wrap or saturate). Build option COMPLEX_MUL_SAT_EN is consumed by the top.
// Ports: none (package).

package complex_mul_pkg;

  // Default width of each real/imaginary component.
  localparam int W_DEFAULT = 8;

  // Field positions inside a 2W operand at the default width.
  localparam int RE_HI = 2*W_DEFAULT - 1;
  localparam int RE_LO = W_DEFAULT;
  localparam int IM_HI = W_DEFAULT - 1;
  localparam int IM_LO = 0;

  // Reduce a sign-extended value to out_w bits. With sat set the value is
  // clamped to the signed out_w range; otherwise it is returned unchanged and
  // the caller's narrowing cast performs the two's-complement wrap.
  function automatic logic signed [63:0] fit_2w(input logic signed [63:0] val,
                                                input int unsigned        out_w,
                                                input logic               sat);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (sat && (val > max_v)) begin
      return max_v;
    end
    if (sat && (val < min_v)) begin
      return min_v;
    end
    return val;
  endfunction

endpackage

// File: rtl/complex_mul_pp.sv
// rtl/complex_mul_pp.sv - stage 1: forms and registers the four signed partial products
//
// Purpose: splits c1 = {a, b} and c2 = {c, d} and registers a*c, b*d, a*d,
// b*c as 2W-bit signed values. The registers load every cycle; validity is
// tracked by the top.
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset, clears all partial products
//   c1_i     operand A {real a, imag b}
//   c2_i     operand B {real c, imag d}
//   ac_o     registered a*c
//   bd_o     registered b*d
//   ad_o     registered a*d
//   bc_o     registered b*c

module complex_mul_pp
  import complex_mul_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*W-1:0]        c1_i,
  input  logic [2*W-1:0]        c2_i,
  output logic signed [2*W-1:0] ac_o,
  output logic signed [2*W-1:0] bd_o,
  output logic signed [2*W-1:0] ad_o,
  output logic signed [2*W-1:0] bc_o
);

  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;
  logic signed [W-1:0] d;

  assign a = c1_i[2*W-1:W];
  assign b = c1_i[W-1:0];
  assign c = c2_i[2*W-1:W];
  assign d = c2_i[W-1:0];

  logic signed [2*W-1:0] ac_d, bd_d, ad_d, bc_d;
  logic signed [2*W-1:0] ac_q, bd_q, ad_q, bc_q;

  // Operands are signed, so they are sign-extended to the 2W result width
  // before multiplying; a W x W signed product always fits in 2W bits.
  always_comb begin
    ac_d = a * c;
    bd_d = b * d;
    ad_d = a * d;
    bc_d = b * c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ac_q <= '0;
      bd_q <= '0;
      ad_q <= '0;
      bc_q <= '0;
    end else begin
      ac_q <= ac_d;
      bd_q <= bd_d;
      ad_q <= ad_d;
      bc_q <= bc_d;
    end
  end

  assign ac_o = ac_q;
  assign bd_o = bd_q;
  assign ad_o = ad_q;
  assign bc_o = bc_q;

endmodule

// File: rtl/complex_mul.sv
// rtl/complex_mul.sv - two-stage pipelined signed complex multiplier
//
// Purpose: product = c1 * c2 with c1 = a + jb, c2 = c + jd.
//   real = a*c - b*d, imag = a*d + b*c, each reported in 2W bits.
// Latency 2 cycles, one result per cycle, no backpressure.
// Build option: COMPLEX_MUL_SAT_EN saturates each 2W-bit result instead of
// wrapping; ports are identical either way.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset, flushes the pipeline
//   in_valid   c1/c2 valid this cycle
//   c1         operand A {real a, imag b}, signed fields
//   c2         operand B {real c, imag d}, signed fields
//   out_valid  product valid (in_valid delayed by 2)
//   product    {real, imag}, signed 2W-bit fields

module complex_mul
  import complex_mul_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*W-1:0] c1,
  input  logic [2*W-1:0] c2,
  output logic           out_valid,
  output logic [4*W-1:0] product
);

`ifdef COMPLEX_MUL_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Stage 1: partial products and valid.
  logic signed [2*W-1:0] ac, bd, ad, bc;
  logic                  vld1_q;

  complex_mul_pp #(
    .W (W)
  ) u_pp (
    .clk   (clk),
    .rst_n (rst_n),
    .c1_i  (c1),
    .c2_i  (c2),
    .ac_o  (ac),
    .bd_o  (bd),
    .ad_o  (ad),
    .bc_o  (bc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
    end else begin
      vld1_q <= in_valid;
    end
  end

  // Stage 2: combine at 2W+1 bits so the sum/difference is exact, then fit
  // back into 2W bits. Only the imag sum can exceed 2W bits, and only when
  // all four components are the most negative value.
  logic signed [2*W:0]   re_full;
  logic signed [2*W:0]   im_full;
  logic        [2*W-1:0] re_d, im_d;
  logic        [2*W-1:0] re_q, im_q;
  logic                  vld2_q;

  always_comb begin
    re_full = $signed({ac[2*W-1], ac}) - $signed({bd[2*W-1], bd});
    im_full = $signed({ad[2*W-1], ad}) + $signed({bc[2*W-1], bc});
    re_d    = (2*W)'(fit_2w(64'(re_full), 2*W, SAT_EN));
    im_d    = (2*W)'(fit_2w(64'(im_full), 2*W, SAT_EN));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_q   <= '0;
      im_q   <= '0;
      vld2_q <= 1'b0;
    end else begin
      re_q   <= re_d;
      im_q   <= im_d;
      vld2_q <= vld1_q;
    end
  end

  assign out_valid = vld2_q;
  assign product   = {re_q, im_q};

endmodule

// File: tb/tb_complex_mul.sv
// tb/tb_complex_mul.sv - self-checking bench for complex_mul

module tb_complex_mul;
  import complex_mul_pkg::*;

  localparam int NH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] c1 = '0;
  logic [15:0] c2 = '0;
  logic        out_valid;
  logic [31:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Input history as seen at each rising edge.
  logic        hv [NH];
  logic        hr [NH];
  logic [15:0] h1 [NH];
  logic [15:0] h2 [NH];

  always #5 clk = ~clk;

  complex_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .c1        (c1),
    .c2        (c2),
    .out_valid (out_valid),
    .product   (product)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] fit16(input int v);
    int r;
    logic [31:0] t;
    r = v;
`ifdef COMPLEX_MUL_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    t = r;
    return t[15:0];
  endfunction

  // Reference: plain integer complex multiply on the packed fields.
  function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
    logic signed [7:0] f;
    int a, b, c, d;
    f = x[RE_HI:RE_LO]; a = f;
    f = x[IM_HI:IM_LO]; b = f;
    f = y[RE_HI:RE_LO]; c = f;
    f = y[IM_HI:IM_LO]; d = f;
    return {fit16(a*c - b*d), fit16(a*d + b*c)};
  endfunction

  always @(posedge clk) begin
    if (cyc < NH) begin
      hv[cyc] <= in_valid;
      hr[cyc] <= rst_n;
      h1[cyc] <= c1;
      h2[cyc] <= c2;
    end
    cyc <= cyc + 1;
  end

  // Every cycle: output after edge k reflects inputs sampled at edge k-1,
  // provided reset was high on both edges.
  always @(negedge clk) begin
    int k;
    logic r0, r1, ev;
    k = cyc - 1;
    if (k >= 0 && k < NH) begin
      r0 = hr[k];
      r1 = (k >= 1) ? hr[k-1] : 1'b0;
      ev = r0 && r1 && hv[k-1];
      chk("out_valid", {31'b0, out_valid}, {31'b0, ev});
      if (!r0 || !r1) begin
        chk("product_flushed", product, 32'h0);
      end else if (ev) begin
        chk("product_model", product, model(h1[k-1], h2[k-1]));
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
    @(posedge clk);
    #1;
    rst_n = r;
    in_valid = v;
    c1 = x;
    c2 = y;
  endtask

  task automatic directed(input string nm, input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] expv);
    drive(1'b1, 1'b1, x, y);
    drive(1'b1, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    chk(nm, product, expv);
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // Reset held for 3 cycles with traffic on the inputs.
    rst_n = 1'b0;
    in_valid = 1'b1;
    c1 = 16'h1234;
    c2 = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_product", product, 32'h0);

    // First accepted input is the one present on the first edge with rst_n = 1.
    rst_n = 1'b1;
    c1 = 16'h0202;
    c2 = 16'h0602;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_latency", n, 2);
    chk("basic", product, 32'h0008_0010);

    directed("mixed_a",  16'h0808, 16'h1E08, 32'h00B0_0130);
    directed("mixed_b",  16'h0B88, 16'h0008, 32'h03C0_0058);
    directed("neg_one",  16'hFFFF, 16'hFFFF, 32'h0000_0002);
    directed("neg_mix",  16'h0868, 16'h0208, 32'hFCD0_0110);
`ifdef COMPLEX_MUL_SAT_EN
    directed("corner",   16'h8080, 16'h8080, 32'h0000_7FFF);
`else
    directed("corner",   16'h8080, 16'h8080, 32'h0000_8000);
`endif

    // Streaming: back-to-back valids, then an irregular pattern.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    end
    drive(1'b1, 1'b1, 16'h8080, 16'h8080);

    // Reset mid-stream drops whatever is in flight.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    end
    drive(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 16'($urandom), 16'($urandom));
    end
    repeat (4) drive(1'b1, 1'b0, 16'h0, 16'h0);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
